mips_multicycle_ctrl: RTL and testbench

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/mips_alu_decoder_p.sv | 42 ++++
 rtl/mips_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Optional macro MIPS_CTRL_JAL_EN adds the JAL state.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BEQ      = 4'd8,
      S_BNE      = 4'd9,
      S_IEXEC    = 4'd10,
      S_IWB      = 4'd11,
      S_JUMP     = 4'd12
`ifdef MIPS_CTRL_JAL_EN
      , S_JAL    = 4'd13
`endif
   } state_e;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_XOR = 3'b011,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctrl_e;

   // How the ALU decoder picks its operation.
   typedef enum logic [1:0] {
      AOP_ADD   = 2'd0,
      AOP_SUB   = 2'd1,
      AOP_FUNCT = 2'd2,
      AOP_IMM   = 2'd3
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mips_alu_decoder_p.sv
// Combinational ALU operation decode from ALUOp, R-type funct and I-type opcode.
module mips_alu_decoder_p
   import mips_ctrl_pkg::*;
(
   input  alu_op_e     alu_op,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output alu_ctrl_e   alu_ctrl,
   output logic        funct_ok
);

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      alu_ctrl = ALU_ADD;
      funct_ok = 1'b1;
      case (alu_op)
         AOP_ADD: alu_ctrl = ALU_ADD;
         AOP_SUB: alu_ctrl = ALU_SUB;
         AOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_XOR:  alu_ctrl = ALU_XOR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: funct_ok = 1'b0;
            endcase
         end
         AOP_IMM: begin
            case (opcode)
               OP_ANDI: alu_ctrl = ALU_AND;
               OP_ORI:  alu_ctrl = ALU_OR;
               OP_XORI: alu_ctrl = ALU_XOR;
               OP_SLTI: alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with wait-stated memory states and an illegal-instruction counter.
// Optional macro MIPS_CTRL_JAL_EN enables the JAL state for opcode 000011.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   output logic [2:0]       ALUControl,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSrc,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             Branch,
   output logic             BranchNE,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic [1:0]       MemtoReg,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt,
   output logic [3:0]       state_o
);

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   state_e           state_q, state_d;
   logic [3:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   alu_op_e   alu_op;
   alu_ctrl_e dec_ctrl;
   logic      funct_ok, alu_en, last_cycle;
   logic      ir_write, pc_write, mem_write, reg_write;

   mips_alu_decoder_p u_alu_dec (
      .alu_op   (alu_op),
      .opcode   (opcode),
      .funct    (funct),
      .alu_ctrl (dec_ctrl),
      .funct_ok (funct_ok)
   );

   assign last_cycle = (wait_q == WAIT_LAST);

   always_comb begin
      state_d    = state_q;
      wait_d     = '0;
      alu_op     = AOP_ADD;
      alu_en     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      Branch     = 1'b0;
      BranchNE   = 1'b0;
      reg_write  = 1'b0;
      RegDst     = 2'b00;
      MemtoReg   = 2'b00;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_en  = 1'b1;
            ALUSrcB = 2'b01;
            MemRead = 1'b1;
            if (last_cycle) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         S_DECODE: begin
            alu_en  = 1'b1;
            ALUSrcB = 2'b11;
            case (opcode)
               OP_LW, OP_SW:  state_d = S_MEMADR;
               OP_RTYPE:      state_d = S_EXECUTE;
               OP_BEQ:        state_d = S_BEQ;
               OP_BNE:        state_d = S_BNE;
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
                              state_d = S_IEXEC;
               OP_J:          state_d = S_JUMP;
`ifdef MIPS_CTRL_JAL_EN
               OP_JAL:        state_d = S_JAL;
`endif
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_en  = 1'b1;
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (last_cycle) state_d = S_MEMWB;
            else            wait_d  = wait_q + 4'd1;
         end
         S_MEMWB: begin
            reg_write = 1'b1;
            MemtoReg  = 2'b01;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            IorD = 1'b1;
            if (last_cycle) begin
               mem_write = 1'b1;
               state_d   = S_FETCH;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         S_EXECUTE: begin
            alu_en  = 1'b1;
            alu_op  = AOP_FUNCT;
            ALUSrcA = 1'b1;
            if (funct_ok) begin
               state_d = S_ALUWB;
            end else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            RegDst    = 2'b01;
            state_d   = S_FETCH;
         end
         S_BEQ, S_BNE: begin
            alu_en   = 1'b1;
            alu_op   = AOP_SUB;
            ALUSrcA  = 1'b1;
            PCSrc    = 2'b01;
            Branch   = 1'b1;
            BranchNE = (state_q == S_BNE);
            state_d  = S_FETCH;
         end
         S_IEXEC: begin
            alu_en  = 1'b1;
            alu_op  = AOP_IMM;
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = S_IWB;
         end
         S_IWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
            state_d  = S_FETCH;
         end
`ifdef MIPS_CTRL_JAL_EN
         S_JAL: begin
            PCSrc     = 2'b10;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            RegDst    = 2'b10;
            MemtoReg  = 2'b10;
            state_d   = S_FETCH;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   // Write strobes are gated by reset so nothing is written while it is held low.
   assign ALUControl  = alu_en ? 3'(dec_ctrl) : 3'b000;
   assign IRWrite     = ir_write  & reset;
   assign PCWrite     = pc_write  & reset;
   assign MemWrite    = mem_write & reset;
   assign RegWrite    = reg_write & reset;
   assign illegal_cnt = cnt_q;
   assign state_o     = state_q;

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: three instances (default, WAIT_CYCLES=2, CNT_W=2).
// JAL expectations follow MIPS_CTRL_JAL_EN.
module tb_mips_multicycle_ctrl;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_a, rst_b, rst_c;
   logic [5:0] op_a, fn_a, op_b, fn_b, op_c, fn_c;

   logic [2:0] a_alu, b_alu, c_alu;
   logic       a_sa, b_sa, c_sa;
   logic [1:0] a_sb, b_sb, c_sb, a_pcs, b_pcs, c_pcs;
   logic       a_iord, a_mr, a_mw, a_irw, a_pcw, a_br, a_bne, a_rw, a_ill;
   logic       b_iord, b_mr, b_mw, b_irw, b_pcw, b_br, b_bne, b_rw, b_ill;
   logic       c_iord, c_mr, c_mw, c_irw, c_pcw, c_br, c_bne, c_rw, c_ill;
   logic [1:0] a_rd, b_rd, c_rd, a_m2r, b_m2r, c_m2r;
   logic [7:0] a_cnt, b_cnt;
   logic [1:0] c_cnt;
   logic [3:0] a_st, b_st, c_st;

   // Word layout: {ALUControl, ALUSrcA, ALUSrcB, PCSrc,
   //               IorD MemRead MemWrite IRWrite PCWrite Branch BranchNE RegWrite, RegDst, MemtoReg}
   logic [19:0] word_a, word_b;
   assign word_a = {a_alu, a_sa, a_sb, a_pcs, a_iord, a_mr, a_mw, a_irw, a_pcw, a_br, a_bne, a_rw, a_rd, a_m2r};
   assign word_b = {b_alu, b_sa, b_sb, b_pcs, b_iord, b_mr, b_mw, b_irw, b_pcw, b_br, b_bne, b_rw, b_rd, b_m2r};

   localparam logic [19:0] W_FETCH      = {3'b010, 1'b0, 2'b01, 2'b00, 8'b0101_1000, 2'b00, 2'b00};
   localparam logic [19:0] W_FETCH_WAIT = {3'b010, 1'b0, 2'b01, 2'b00, 8'b0100_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_DECODE     = {3'b010, 1'b0, 2'b11, 2'b00, 8'b0000_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_MEMADR     = {3'b010, 1'b1, 2'b10, 2'b00, 8'b0000_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_MEMREAD    = {3'b000, 1'b0, 2'b00, 2'b00, 8'b1100_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_MEMWB      = {3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_0001, 2'b00, 2'b01};
   localparam logic [19:0] W_MW_WAIT    = {3'b000, 1'b0, 2'b00, 2'b00, 8'b1000_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_MW_LAST    = {3'b000, 1'b0, 2'b00, 2'b00, 8'b1010_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_EX_XOR     = {3'b011, 1'b1, 2'b00, 2'b00, 8'b0000_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_EX_BAD     = {3'b010, 1'b1, 2'b00, 2'b00, 8'b0000_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_ALUWB      = {3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_0001, 2'b01, 2'b00};
   localparam logic [19:0] W_BNE        = {3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0110, 2'b00, 2'b00};
   localparam logic [19:0] W_IEX_OR     = {3'b001, 1'b1, 2'b10, 2'b00, 8'b0000_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_IEX_SLT    = {3'b111, 1'b1, 2'b10, 2'b00, 8'b0000_0000, 2'b00, 2'b00};
   localparam logic [19:0] W_IWB        = {3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_0001, 2'b00, 2'b00};
   localparam logic [19:0] W_JAL        = {3'b000, 1'b0, 2'b00, 2'b10, 8'b0000_1001, 2'b10, 2'b10};

   localparam logic [19:0] ST_FETCH = 20'd0,  ST_DECODE = 20'd1,  ST_MEMADR = 20'd2;
   localparam logic [19:0] ST_MEMRD = 20'd3,  ST_MEMWB  = 20'd4,  ST_MEMWR  = 20'd5;
   localparam logic [19:0] ST_EXEC  = 20'd6,  ST_ALUWB  = 20'd7,  ST_BNE    = 20'd9;
   localparam logic [19:0] ST_IEXEC = 20'd10, ST_IWB    = 20'd11, ST_JAL    = 20'd13;

   mips_multicycle_ctrl u_a (
      .clock(clock), .reset(rst_a), .opcode(op_a), .funct(fn_a),
      .ALUControl(a_alu), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .PCSrc(a_pcs),
      .IorD(a_iord), .MemRead(a_mr), .MemWrite(a_mw), .IRWrite(a_irw), .PCWrite(a_pcw),
      .Branch(a_br), .BranchNE(a_bne), .RegWrite(a_rw), .RegDst(a_rd), .MemtoReg(a_m2r),
      .illegal(a_ill), .illegal_cnt(a_cnt), .state_o(a_st)
   );

   mips_multicycle_ctrl #(.WAIT_CYCLES(2)) u_b (
      .clock(clock), .reset(rst_b), .opcode(op_b), .funct(fn_b),
      .ALUControl(b_alu), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .PCSrc(b_pcs),
      .IorD(b_iord), .MemRead(b_mr), .MemWrite(b_mw), .IRWrite(b_irw), .PCWrite(b_pcw),
      .Branch(b_br), .BranchNE(b_bne), .RegWrite(b_rw), .RegDst(b_rd), .MemtoReg(b_m2r),
      .illegal(b_ill), .illegal_cnt(b_cnt), .state_o(b_st)
   );

   mips_multicycle_ctrl #(.CNT_W(2)) u_c (
      .clock(clock), .reset(rst_c), .opcode(op_c), .funct(fn_c),
      .ALUControl(c_alu), .ALUSrcA(c_sa), .ALUSrcB(c_sb), .PCSrc(c_pcs),
      .IorD(c_iord), .MemRead(c_mr), .MemWrite(c_mw), .IRWrite(c_irw), .PCWrite(c_pcw),
      .Branch(c_br), .BranchNE(c_bne), .RegWrite(c_rw), .RegDst(c_rd), .MemtoReg(c_m2r),
      .illegal(c_ill), .illegal_cnt(c_cnt), .state_o(c_st)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the falling edge.
   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   initial begin
      int exp_cnt [5] = '{0, 1, 2, 3, 3};
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      op_a = 6'b100011; fn_a = 6'b000000;
      op_b = 6'b000010; fn_b = 6'b000000;
      op_c = 6'b000010; fn_c = 6'b000000;
      #2;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      #1;
      check("rst.state", 20'(a_st), ST_FETCH);
      check("rst.word",  word_a, W_FETCH_WAIT);
      check("rst.cnt",   20'(a_cnt), 20'd0);
      check("rst.ill",   20'(a_ill), 20'd0);

      // lw with no wait states
      tick(); rst_a = 1'b1; #1;
      check("lw.fetch.st", 20'(a_st), ST_FETCH);
      check("lw.fetch",    word_a, W_FETCH);
      tick(); check("lw.decode.st", 20'(a_st), ST_DECODE); check("lw.decode", word_a, W_DECODE);
      tick(); check("lw.memadr.st", 20'(a_st), ST_MEMADR); check("lw.memadr", word_a, W_MEMADR);
      tick(); check("lw.memread.st", 20'(a_st), ST_MEMRD); check("lw.memread", word_a, W_MEMREAD);
      tick(); check("lw.memwb.st", 20'(a_st), ST_MEMWB); check("lw.memwb", word_a, W_MEMWB);
      op_a = 6'b000000; fn_a = 6'b100110;

      // R-type xor
      tick(); check("xor.fetch.st", 20'(a_st), ST_FETCH);
      tick(); check("xor.decode.st", 20'(a_st), ST_DECODE);
      tick(); check("xor.exec.st", 20'(a_st), ST_EXEC); check("xor.exec", word_a, W_EX_XOR);
      check("xor.exec.ill", 20'(a_ill), 20'd0);
      tick(); check("xor.aluwb.st", 20'(a_st), ST_ALUWB); check("xor.aluwb", word_a, W_ALUWB);
      fn_a = 6'b111111;

      // R-type with unmapped funct
      tick(); tick();
      tick(); check("badfn.exec.st", 20'(a_st), ST_EXEC); check("badfn.exec", word_a, W_EX_BAD);
      check("badfn.ill", 20'(a_ill), 20'd1); check("badfn.cnt0", 20'(a_cnt), 20'd0);
      op_a = 6'b000101;
      tick(); check("badfn.ret.st", 20'(a_st), ST_FETCH); check("badfn.cnt1", 20'(a_cnt), 20'd1);
      check("badfn.ret.ill", 20'(a_ill), 20'd0);

      // bne
      tick(); tick(); check("bne.st", 20'(a_st), ST_BNE); check("bne.word", word_a, W_BNE);
      op_a = 6'b001101;

      // ori then slti
      tick(); tick();
      tick(); check("ori.iexec.st", 20'(a_st), ST_IEXEC); check("ori.iexec", word_a, W_IEX_OR);
      tick(); check("ori.iwb.st", 20'(a_st), ST_IWB); check("ori.iwb", word_a, W_IWB);
      op_a = 6'b001010;
      tick(); tick();
      tick(); check("slti.iexec", word_a, W_IEX_SLT);
      tick(); op_a = 6'b000011;

      // jal
      tick(); check("jal.fetch.st", 20'(a_st), ST_FETCH);
      tick(); check("jal.decode.st", 20'(a_st), ST_DECODE);
`ifdef MIPS_CTRL_JAL_EN
      check("jal.decode.ill", 20'(a_ill), 20'd0);
      tick(); check("jal.st", 20'(a_st), ST_JAL); check("jal.word", word_a, W_JAL);
`else
      check("jal.decode.ill", 20'(a_ill), 20'd1);
      check("jal.decode.rw", 20'(a_rw), 20'd0);
      tick(); check("jal.ret.st", 20'(a_st), ST_FETCH); check("jal.cnt", 20'(a_cnt), 20'd2);
`endif

      // sw with two wait states
      op_b = 6'b101011;
      tick(); rst_b = 1'b1; #1;
      check("sw.f1.st", 20'(b_st), ST_FETCH); check("sw.f1", word_b, W_FETCH_WAIT);
      tick(); check("sw.f2.st", 20'(b_st), ST_FETCH); check("sw.f2", word_b, W_FETCH_WAIT);
      tick(); check("sw.f3.st", 20'(b_st), ST_FETCH); check("sw.f3", word_b, W_FETCH);
      tick(); check("sw.decode.st", 20'(b_st), ST_DECODE);
      tick(); check("sw.memadr.st", 20'(b_st), ST_MEMADR);
      tick(); check("sw.mw1.st", 20'(b_st), ST_MEMWR); check("sw.mw1", word_b, W_MW_WAIT);
      tick(); check("sw.mw2.st", 20'(b_st), ST_MEMWR); check("sw.mw2", word_b, W_MW_WAIT);
      tick(); check("sw.mw3.st", 20'(b_st), ST_MEMWR); check("sw.mw3", word_b, W_MW_LAST);
      op_b = 6'b100011;

      // lw with reset in the second MEMREAD wait cycle
      tick(); check("lwr.f1.st", 20'(b_st), ST_FETCH);
      tick(); tick(); tick(); tick();
      tick(); check("lwr.mr1.st", 20'(b_st), ST_MEMRD); check("lwr.mr1", word_b, W_MEMREAD);
      tick(); check("lwr.mr2.st", 20'(b_st), ST_MEMRD);
      tick(); check("lwr.mr3.st", 20'(b_st), ST_MEMRD);
      rst_b = 1'b0; #1;
      check("lwr.abort.st", 20'(b_st), ST_FETCH);
      check("lwr.abort", word_b, W_FETCH_WAIT);
      tick(); check("lwr.held.st", 20'(b_st), ST_FETCH);
      rst_b = 1'b1; #1;
      check("lwr.rf1", word_b, W_FETCH_WAIT);
      tick(); check("lwr.rf2", word_b, W_FETCH_WAIT);
      tick(); check("lwr.rf3", word_b, W_FETCH);
      tick(); check("lwr.decode.st", 20'(b_st), ST_DECODE);

      // saturating illegal counter, CNT_W=2
      op_c = 6'b111111;
      tick(); rst_c = 1'b1; #1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("sat.cnt%0d", i), 20'(c_cnt), 20'(exp_cnt[i]));
         tick();
         check($sformatf("sat.ill%0d", i), 20'(c_ill), 20'd1);
         tick();
      end
      check("sat.final", 20'(c_cnt), 20'd3);
      check("sat.st", 20'(c_st), ST_FETCH);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
